// File: rtl/ram_clr.sv
// ram_clr: DEPTH x DATA_W RAM with a masked write port, a registered read
// port, and a self-clearing sweep. After reset, or when clr is requested,
// the array is zeroed one word per clock. The port is unavailable while
// this runs.
//
// Ports:
//   i_clk          clock; all state updates on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_clr          request to clear the whole array (accepted only in IDLE)
//   i_write_en     write strobe
//   i_write_addr   write address
//   i_write_data   write data
//   i_write_mask   per-bit write enable (1 = bit updated)
//   i_read_en      read strobe
//   i_read_addr    read address
//   o_read_data    registered read data (holds when no read completes)
//   o_read_valid   o_read_data was updated on the last edge
//   o_busy         clear sweep in progress
module ram_clr #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_write_en,
    input  logic [ADDR_W-1:0] i_write_addr,
    input  logic [DATA_W-1:0] i_write_data,
    input  logic [DATA_W-1:0] i_write_mask,
    input  logic              i_read_en,
    input  logic [ADDR_W-1:0] i_read_addr,
    output logic [DATA_W-1:0] o_read_data,
    output logic              o_read_valid,
    output logic              o_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] counter;
    logic [ADDR_W-1:0] counter_next;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              idle_go;
    logic              wr_go;
    logic              rd_go;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= CLEAR;
            counter <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    // Next-state logic. The sweep ends on the edge that writes the
    // last address; the counter then wraps to 0 on its own.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        case (state)
            CLEAR: begin
                counter_next = counter + ADDR_W'(1);
                if (counter == '1) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (i_clr) begin
                    counter_next = '0;
                    state_next   = CLEAR;
                end
            end
            default: begin
                state_next   = CLEAR;
                counter_next = '0;
            end
        endcase
    end

    // Output/decode logic. o_busy comes straight from the state flop.
    // Clear takes priority over any access issued in the same cycle.
    always_comb begin
        o_busy  = (state == CLEAR);
        idle_go = (state == IDLE) && !i_clr;
        wr_go   = idle_go && i_write_en;
        rd_go   = idle_go && i_read_en;
    end

    // Storage has no reset; the sweep zeroes it.
    always_ff @(posedge i_clk) begin
        if (state == CLEAR) begin
            mem[counter] <= '0;
        end else if (wr_go) begin
            mem[i_write_addr] <= (mem[i_write_addr] & ~i_write_mask)
                               | (i_write_data & i_write_mask);
        end
    end

    // Registered read port. A read and a write to the same address on one
    // edge both sample the array before it updates, so the read returns
    // the old word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_read_data  <= '0;
            o_read_valid <= 1'b0;
        end else begin
            o_read_valid <= rd_go;
            if (rd_go) begin
                o_read_data <= mem[i_read_addr];
            end
        end
    end

endmodule

// File: tb/tb_ram_clr.sv
module tb_ram_clr;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              write_en;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] write_mask;
    logic              read_en;
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              busy;

    ram_clr #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clr        (clr),
        .i_write_en   (write_en),
        .i_write_addr (write_addr),
        .i_write_data (write_data),
        .i_write_mask (write_mask),
        .i_read_en    (read_en),
        .i_read_addr  (read_addr),
        .o_read_data  (read_data),
        .o_read_valid (read_valid),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned       n_checks;
    int unsigned       n_errors;
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] mem_m [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge, then compare the read port against the scoreboard.
    task automatic tick();
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            check("read_valid", 32'(read_valid), 32'd1);
            check("read_data", 32'(read_data), 32'(exp_q.pop_front()));
        end else begin
            check("read_valid_idle", 32'(read_valid), 32'd0);
        end
    endtask

    task automatic idle_inputs();
        clr = 1'b0; write_en = 1'b0; read_en = 1'b0;
        write_addr = '0; write_data = '0; write_mask = '0; read_addr = '0;
    endtask

    // Drive one IDLE-state operation; the model and scoreboard follow it.
    task automatic op(input logic we, input logic [ADDR_W-1:0] wa,
                      input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] wm,
                      input logic re, input logic [ADDR_W-1:0] ra);
        write_en = we; write_addr = wa; write_data = wd; write_mask = wm;
        read_en = re; read_addr = ra;
        if (re) exp_q.push_back(mem_m[ra]);
        if (we) mem_m[wa] = (mem_m[wa] & ~wm) | (wd & wm);
        tick();
        idle_inputs();
    endtask

    // Count edges until busy drops, hammering the ports meanwhile; those
    // accesses must have no effect. Bounded so a stuck DUT still finishes.
    task automatic sweep(input string tag, input int unsigned exp_edges);
        int unsigned n;
        n = 0;
        while (busy && n < 40) begin
            write_en = 1'b1; write_addr = '0; write_data = '1; write_mask = '1;
            read_en = 1'b1; read_addr = '0; clr = n[0];
            tick();
            n++;
        end
        idle_inputs();
        check(tag, n, exp_edges);
        for (int unsigned i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        for (int unsigned i = 0; i < DEPTH; i++) mem_m[i] = '0;

        rst_n = 1'b0;
        #3;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_valid", 32'(read_valid), 32'd0);
        check("rst_data", 32'(read_data), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        check("rel_busy", 32'(busy), 32'd1);
        sweep("sweep_after_reset", 8);

        // All words zero after the initial sweep
        for (int unsigned a = 0; a < DEPTH; a++) op(1'b0, '0, '0, '0, 1'b1, ADDR_W'(a));
        op(1'b0, '0, '0, '0, 1'b0, '0);

        // Full write and read back, then valid drops
        op(1'b1, 3'd3, 4'h7, 4'hF, 1'b0, '0);
        op(1'b0, '0, '0, '0, 1'b1, 3'd3);
        op(1'b0, '0, '0, '0, 1'b0, '0);
        check("hold_data", 32'(read_data), 32'h7);

        // Masked write: F then 0 under mask 3 -> C
        op(1'b1, 3'd5, 4'hF, 4'hF, 1'b0, '0);
        op(1'b1, 3'd5, 4'h0, 4'h3, 1'b0, '0);
        op(1'b0, '0, '0, '0, 1'b1, 3'd5);
        check("mask_value", 32'(mem_m[5]), 32'hC);

        // Read-first on collision
        op(1'b1, 3'd7, 4'h5, 4'hF, 1'b0, '0);
        op(1'b1, 3'd7, 4'hA, 4'hF, 1'b1, 3'd7);
        op(1'b0, '0, '0, '0, 1'b1, 3'd7);

        // Independent read and write on different addresses
        op(1'b1, 3'd1, 4'h6, 4'hF, 1'b1, 3'd3);
        op(1'b0, '0, '0, '0, 1'b1, 3'd1);

        // Random masked traffic against the model
        for (int unsigned i = 0; i < 40; i++) begin
            op(1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom),
               DATA_W'($urandom), 1'($urandom_range(0, 1)), ADDR_W'($urandom));
        end

        // Clear wins over a same-cycle write and read
        write_en = 1'b1; write_addr = 3'd2; write_data = 4'h9; write_mask = 4'hF;
        read_en = 1'b1; read_addr = 3'd2; clr = 1'b1;
        tick();
        idle_inputs();
        check("clr_busy", 32'(busy), 32'd1);
        sweep("sweep_after_clr", 8);
        for (int unsigned a = 0; a < DEPTH; a++) op(1'b0, '0, '0, '0, 1'b1, ADDR_W'(a));

        // Reset in mid-sweep aborts it; a full sweep follows release
        op(1'b1, 3'd4, 4'hB, 4'hF, 1'b0, '0);
        op(1'b0, '0, '0, '0, 1'b1, 3'd4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (4) tick();
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_data_held", 32'(read_data), 32'hB);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_valid", 32'(read_valid), 32'd0);
        check("abort_data", 32'(read_data), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        sweep("sweep_after_abort", 8);
        for (int unsigned a = 0; a < DEPTH; a++) op(1'b0, '0, '0, '0, 1'b1, ADDR_W'(a));
        op(1'b0, '0, '0, '0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_clr.md
RAM_CLR -- requirements
Module: ram_clr

Interface
REQ-001 Parameter DATA_W, default 4, SHALL set the word width in bits (1 or more).
REQ-002 Parameter ADDR_W, default 3, SHALL set the address width (1 or more); DEPTH = 2**ADDR_W words.
REQ-003 Port i_clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port i_clr, input, 1: request to clear the whole array.
REQ-006 Port i_write_en, input, 1: write strobe.
REQ-007 Port i_write_addr, input, ADDR_W: write address.
REQ-008 Port i_write_data, input, DATA_W: write data.
REQ-009 Port i_write_mask, input, DATA_W: per-bit write enable (1 means the bit is updated).
REQ-010 Port i_read_en, input, 1: read strobe.
REQ-011 Port i_read_addr, input, ADDR_W: read address.
REQ-012 Port o_read_data, output, DATA_W: registered read data.
REQ-013 Port o_read_valid, output, 1: o_read_data was updated on the last edge.
REQ-014 Port o_busy, output, 1: clear sweep in progress; the array is unavailable.

Function
REQ-015 The block SHALL hold DEPTH x DATA_W storage plus a two-state FSM (CLEAR, IDLE) and an ADDR_W-bit sweep counter.
REQ-016 In CLEAR, each edge SHALL write 0 to mem[counter] and increment the counter.
REQ-017 The edge that writes address DEPTH-1 SHALL move the FSM to IDLE, so CLEAR lasts exactly DEPTH edges.
REQ-018 o_busy SHALL equal 1 exactly when the FSM is in CLEAR (registered, no combinational path).
REQ-019 In CLEAR, i_write_en, i_read_en and i_clr SHALL be ignored; o_read_valid SHALL stay 0 and o_read_data SHALL hold.
REQ-020 In IDLE, i_clr=1 at an edge SHALL reset the counter to 0 and enter CLEAR; any write or read in that same cycle SHALL be dropped (clear has priority).
REQ-021 In IDLE with i_write_en=1, each bit b of mem[i_write_addr] SHALL take i_write_data[b] where i_write_mask[b]=1 and keep its old value otherwise.
REQ-022 In IDLE with i_read_en=1, the edge SHALL load o_read_data with mem[i_read_addr] and set o_read_valid=1 (read latency 1 cycle).
REQ-023 In IDLE with i_read_en=0, the edge SHALL clear o_read_valid to 0 and o_read_data SHALL hold.
REQ-024 A read and a write to the same address on the same edge SHALL return the old contents (read-first); the new data is visible from the next read.
REQ-025 A read and a write to different addresses on the same edge SHALL both complete independently.
REQ-026 Address arithmetic SHALL be modulo DEPTH; there is no out-of-range case.

Reset
REQ-027 While i_rst_n=0, regardless of clock: FSM=CLEAR, counter=0, o_busy=1, o_read_valid=0, o_read_data=0.
REQ-028 The storage array SHALL NOT be reset directly; it SHALL be zeroed by the CLEAR sweep starting at the first edge after i_rst_n rises.
REQ-029 Assertion of i_rst_n mid-sweep SHALL abort the sweep; after release the sweep SHALL restart from address 0 and run a full DEPTH edges.

Verification (DATA_W=4, ADDR_W=3)
REQ-030 Release reset, no stimulus -> o_busy=1 for exactly 8 edges then 0; reads of addresses 0..7 each return 0 with o_read_valid=1 one cycle later.
REQ-031 Write addr 3, data 7, mask F; then read addr 3 -> o_read_data=7 and o_read_valid=1 for one cycle; o_read_valid=0 afterwards with i_read_en=0.
REQ-032 Write addr 5, data F, mask F; then write addr 5, data 0, mask 3; then read addr 5 -> o_read_data=C.
REQ-033 With addr 7 holding 5, write data A to addr 7 and read addr 7 on the same edge -> read returns 5; the next read returns A.
REQ-034 In IDLE, assert i_clr together with a write of 9 to addr 2 -> o_busy=1 for 8 edges, writes and reads issued during the sweep are ignored, and addr 2 then reads 0.
REQ-035 Assert i_rst_n=0 after 4 sweep edges -> outputs return to reset values immediately; after release o_busy stays 1 for a full 8 edges.
